// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, datapath mux selects, ALU operation classes and immediate formats.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_REG    = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_PASS_B = 2'b11;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_SHIFT = 3'b101;

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational opcode/funct3 -> immediate-format select.
// Ports: opcode_i, funct_3_i in; imm_src_o out (IMM_* encoding).
module imm_src_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct_3_i,
    output logic [2:0] imm_src_o
);

    logic is_shift;

    // SLLI/SRLI/SRAI share funct3[1:0] = 01
    assign is_shift = (opcode_i == OP_IMM) && (funct_3_i[1:0] == 2'b01);

    always_comb begin
        imm_src_o = IMM_I;
        unique case (1'b1)
            (opcode_i == OP_STORE):  imm_src_o = IMM_S;
            (opcode_i == OP_BRANCH): imm_src_o = IMM_B;
            (opcode_i == OP_LUI),
            (opcode_i == OP_AUIPC):  imm_src_o = IMM_U;
            (opcode_i == OP_JAL):    imm_src_o = IMM_J;
            is_shift:                imm_src_o = IMM_SHIFT;
            default:                 imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath: drives mux selects and
// write enables per cycle, stalls on mem_ready_i, traps on illegal opcodes.
// Ports: clk, rst (async high), opcode_i, funct_3_i, mem_ready_i in;
// pc/branch/mem/ir/reg enables, adr/result/alu selects, imm_src_o,
// retire_o, illegal_o out. Define RETIRE_CNT_EN to add retire_cnt_o.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int RETIRE_CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct_3_i,
    input  logic       mem_ready_i,
    output logic       pc_wr_en_o,
    output logic       branch_o,
    output logic       adr_src_o,
    output logic       mem_wr_en_o,
    output logic       ir_wr_en_o,
    output logic       reg_wr_en_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [2:0] imm_src_o,
    output logic       retire_o,
    output logic       illegal_o
`ifdef RETIRE_CNT_EN
    ,
    output logic [RETIRE_CNT_W-1:0] retire_cnt_o
`endif
);

    if (RETIRE_CNT_W < 1) begin : g_bad_width
        $error("RETIRE_CNT_W must be at least 1");
    end

    state_t state_q;
    state_t state_d;
    logic   illegal_q;

    logic pc_wr;
    logic branch;
    logic mem_wr;
    logic ir_wr;
    logic reg_wr;
    logic retire;

    imm_src_decoder u_imm_src_decoder (
        .opcode_i  (opcode_i),
        .funct_3_i (funct_3_i),
        .imm_src_o (imm_src_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_wr        = 1'b0;
        branch       = 1'b0;
        adr_src_o    = 1'b0;
        mem_wr       = 1'b0;
        ir_wr        = 1'b0;
        reg_wr       = 1'b0;
        retire       = 1'b0;
        result_src_o = RES_ALU_OUT;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_REG;
        alu_op_o     = ALU_ADD;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
                ir_wr        = mem_ready_i;
                pc_wr        = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_o = SRC_A_OLD_PC;
                alu_src_b_o = SRC_B_IMM;
                case (opcode_i)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEM_ADR;
                    OP_R:      state_d = S_EXEC_R;
                    OP_IMM,
                    OP_LUI,
                    OP_AUIPC:  state_d = S_EXEC_I;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a_o = SRC_A_REG;
                alu_src_b_o = SRC_B_IMM;
                state_d = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                adr_src_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                result_src_o = RES_DATA;
                reg_wr       = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                adr_src_o = 1'b1;
                mem_wr    = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a_o = SRC_A_REG;
                alu_op_o    = ALU_FUNCT;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_b_o = SRC_B_IMM;
                state_d     = S_ALU_WB;
                case (opcode_i)
                    OP_LUI: begin
                        alu_op_o = ALU_PASS_B;
                    end
                    OP_AUIPC: begin
                        alu_src_a_o = SRC_A_OLD_PC;
                    end
                    default: begin
                        alu_src_a_o = SRC_A_REG;
                        alu_op_o    = ALU_FUNCT;
                    end
                endcase
            end
            S_ALU_WB: begin
                reg_wr  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = SRC_A_REG;
                alu_op_o    = ALU_BRANCH;
                branch      = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JALR: begin
                alu_src_a_o = SRC_A_REG;
                alu_src_b_o = SRC_B_IMM;
                state_d     = S_JAL;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU
                // computes the link value old-PC + 4 for ALU_WB.
                pc_wr       = 1'b1;
                alu_src_a_o = SRC_A_OLD_PC;
                alu_src_b_o = SRC_B_FOUR;
                state_d     = S_ALU_WB;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Write strobes drop as soon as rst rises, not at the next edge.
    assign pc_wr_en_o  = pc_wr  & ~rst;
    assign branch_o    = branch & ~rst;
    assign mem_wr_en_o = mem_wr & ~rst;
    assign ir_wr_en_o  = ir_wr  & ~rst;
    assign reg_wr_en_o = reg_wr & ~rst;
    assign retire_o    = retire & ~rst;
    assign illegal_o   = illegal_q;

`ifdef RETIRE_CNT_EN
    logic [RETIRE_CNT_W-1:0] retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (retire && state_q != S_TRAP) begin
            retire_cnt_q <= retire_cnt_q + RETIRE_CNT_W'(1);
        end
    end

    assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: randomized instruction
// stream and memory waits checked against a per-instruction timeline model.
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [6:0] opcode_i;
    logic [2:0] funct_3_i;
    logic       mem_ready_i;
    logic       pc_wr_en_o;
    logic       branch_o;
    logic       adr_src_o;
    logic       mem_wr_en_o;
    logic       ir_wr_en_o;
    logic       reg_wr_en_o;
    logic [1:0] result_src_o;
    logic [1:0] alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [1:0] alu_op_o;
    logic [2:0] imm_src_o;
    logic       retire_o;
    logic       illegal_o;
`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int cnt_model = 0;

    logic [14:0] exp_q[$];
    bit          rdy_q[$];

    multicycle_controller #(.RETIRE_CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode_i),
        .funct_3_i    (funct_3_i),
        .mem_ready_i  (mem_ready_i),
        .pc_wr_en_o   (pc_wr_en_o),
        .branch_o     (branch_o),
        .adr_src_o    (adr_src_o),
        .mem_wr_en_o  (mem_wr_en_o),
        .ir_wr_en_o   (ir_wr_en_o),
        .reg_wr_en_o  (reg_wr_en_o),
        .result_src_o (result_src_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .imm_src_o    (imm_src_o),
        .retire_o     (retire_o),
        .illegal_o    (illegal_o)
`ifdef RETIRE_CNT_EN
        ,
        .retire_cnt_o (retire_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control vector:
    // {pc_wr, branch, adr_src, mem_wr, ir_wr, reg_wr,
    //  result_src, src_a, src_b, alu_op, retire}
    function automatic logic [14:0] mk(
        input logic pc, input logic br, input logic adr,
        input logic mw, input logic ir, input logic rw,
        input logic [1:0] res, input logic [1:0] sa,
        input logic [1:0] sb, input logic [1:0] op,
        input logic ret);
        return {pc, br, adr, mw, ir, rw, res, sa, sb, op, ret};
    endfunction

    function automatic logic [14:0] observed();
        return {pc_wr_en_o, branch_o, adr_src_o, mem_wr_en_o,
                ir_wr_en_o, reg_wr_en_o, result_src_o, alu_src_a_o,
                alu_src_b_o, alu_op_o, retire_o};
    endfunction

    // 0 R, 1 OP-IMM, 2 LUI, 3 AUIPC, 4 LOAD, 5 STORE, 6 BRANCH, 7 JAL, 8 JALR
    function automatic logic [6:0] opc_of(input int cls);
        case (cls)
            0: return 7'b0110011;
            1: return 7'b0010011;
            2: return 7'b0110111;
            3: return 7'b0010111;
            4: return 7'b0000011;
            5: return 7'b0100011;
            6: return 7'b1100011;
            7: return 7'b1101111;
            8: return 7'b1100111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [2:0] imm_model(input logic [6:0] op,
                                             input logic [2:0] f3);
        if (op == 7'b0100011) return 3'd1;
        if (op == 7'b1100011) return 3'd2;
        if (op == 7'b0110111 || op == 7'b0010111) return 3'd3;
        if (op == 7'b1101111) return 3'd4;
        if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) return 3'd5;
        return 3'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // r: 0/1 fixed ready value, 2 = random (state must ignore it)
    task automatic push(input logic [14:0] v, input int r);
        exp_q.push_back(v);
        if (r == 2) rdy_q.push_back(bit'($urandom_range(0, 1)));
        else        rdy_q.push_back(r == 1);
    endtask

    // Builds the expected cycle-by-cycle timeline of one instruction and
    // runs it; cut >= 0 stops after that many cycles.
    task automatic run_instr(input int cls, input int fw, input int mw,
                             input int cut);
        logic [14:0] wb;
        logic [14:0] link;
        int n;
        int lim;
        exp_q.delete();
        rdy_q.delete();
        wb   = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        link = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
        for (int k = 0; k < fw; k++)
            push(mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0), 0);
        push(mk(1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0), 1);
        push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0), 2);
        case (cls)
            0: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0), 2);
                push(wb, 2);
            end
            1: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0), 2);
                push(wb, 2);
            end
            2: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b11, 0), 2);
                push(wb, 2);
            end
            3: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0), 2);
                push(wb, 2);
            end
            4: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), 2);
                for (int k = 0; k <= mw; k++)
                    push(mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0),
                         (k == mw) ? 1 : 0);
                push(mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1), 2);
            end
            5: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), 2);
                for (int k = 0; k <= mw; k++)
                    push(mk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00,
                            (k == mw)), (k == mw) ? 1 : 0);
            end
            6: begin
                push(mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1), 2);
            end
            7: begin
                push(link, 2);
                push(wb, 2);
            end
            default: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), 2);
                push(link, 2);
                push(wb, 2);
            end
        endcase
        opcode_i  = opc_of(cls);
        funct_3_i = 3'($urandom_range(0, 7));
        n   = exp_q.size();
        lim = (cut >= 0 && cut < n) ? cut : n;
        for (int i = 0; i < lim; i++) begin
            mem_ready_i = rdy_q[i];
            #3;
            chk($sformatf("ctl cls%0d cyc%0d", cls, i),
                32'(observed()), 32'(exp_q[i]));
            chk($sformatf("illegal cls%0d cyc%0d", cls, i),
                32'(illegal_o), 32'd0);
            if (i == fw + 1)
                chk($sformatf("imm_src cls%0d f3=%0d", cls, funct_3_i),
                    32'(imm_src_o), 32'(imm_model(opcode_i, funct_3_i)));
            @(posedge clk);
            #1;
        end
        if (lim == n) begin
            cnt_model++;
`ifdef RETIRE_CNT_EN
            chk("retire_cnt", retire_cnt_o, 32'(cnt_model));
`endif
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " ctl"}, 32'(observed()),
            32'(mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0)));
        chk({tag, " illegal"}, 32'(illegal_o), 32'd0);
`ifdef RETIRE_CNT_EN
        chk({tag, " retire_cnt"}, retire_cnt_o, 32'd0);
`endif
    endtask

    initial begin
        rst         = 1'b1;
        opcode_i    = 7'b0110011;
        funct_3_i   = 3'd0;
        mem_ready_i = 1'b1;
        #2;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases from the plan
        run_instr(0, 0, 0, -1);
        run_instr(4, 0, 2, -1);
        run_instr(5, 0, 1, -1);
        run_instr(6, 0, 0, -1);
        run_instr(8, 0, 0, -1);
        run_instr(7, 1, 0, -1);
        run_instr(2, 0, 0, -1);
        run_instr(3, 2, 0, -1);

        // Illegal opcode: trap and freeze
        opcode_i    = 7'b0000000;
        mem_ready_i = 1'b1;
        #3;
        chk("trap fetch", 32'(observed()),
            32'(mk(1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0)));
        @(posedge clk);
        #1;
        mem_ready_i = 1'b0;
        #3;
        chk("trap decode illegal", 32'(illegal_o), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            mem_ready_i = 1'($urandom_range(0, 1));
            opcode_i    = opc_of(int'($urandom_range(0, 8)));
            #3;
            chk($sformatf("trap illegal %0d", i), 32'(illegal_o), 32'd1);
            chk($sformatf("trap ctl %0d", i), 32'(observed()), 32'd0);
`ifdef RETIRE_CNT_EN
            chk($sformatf("trap cnt %0d", i), retire_cnt_o, 32'(cnt_model));
`endif
            @(posedge clk);
            #1;
        end

        // Reset out of TRAP, asserted between edges
        mem_ready_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("rst trap");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt_model = 0;
        run_instr(0, 0, 0, -1);

        // Reset mid-load while waiting in MEM_RD
        run_instr(4, 0, 3, 4);
        mem_ready_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("rst mid-lw");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt_model = 0;

        // Randomized instruction stream with random memory waits
        for (int t = 0; t < 60; t++)
            run_instr(int'($urandom_range(0, 8)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), -1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
